blinker_nios2_proc_oci_dct_packer: RTL

- Upstream feeder of the OCI trace test-bench/trace-FIFO stage.
- Packs 2-bit direct-control-transfer (DCT) codes from the Nios II trace front end into a 30-bit buffer (15 slots) with a 4-bit fill count.
- Exposes the live dct_buffer and dct_count to the downstream consumer.
- Emits completed frames over a valid/ready handshake when the buffer fills or a flush is requested.

---
 rtl/blinker_nios2_proc_oci_dct_packer_if.sv | 22 ++
 rtl/blinker_nios2_proc_oci_dct_packer.sv | 95 +++++++++
 2 files changed

// File: rtl/blinker_nios2_proc_oci_dct_packer_if.sv
// Frame handshake between the DCT packer and the trace-FIFO consumer.
// A frame transfers on any rising edge where frame_valid & frame_ready; the
// producer holds frame_data/frame_valid stable while frame_valid & ~frame_ready.
interface blinker_nios2_proc_oci_dct_packer_if #(
    parameter int DW = 34
);
    logic          frame_valid;
    logic          frame_ready;
    logic [DW-1:0] frame_data;

    modport master (
        output frame_valid,
        output frame_data,
        input  frame_ready
    );

    modport slave (
        input  frame_valid,
        input  frame_data,
        output frame_ready
    );
endinterface

// File: rtl/blinker_nios2_proc_oci_dct_packer.sv
// Packs 2-bit DCT codes into a SLOTS-deep shift buffer and emits {count, buffer}
// frames when the buffer fills or a flush is requested.
module blinker_nios2_proc_oci_dct_packer #(
    parameter int SLOTS = 15
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 trc_on,
    input  logic                 dct_valid,
    input  logic [1:0]           dct_code,
    input  logic                 flush,
    blinker_nios2_proc_oci_dct_packer_if.master frm,
    output logic [2*SLOTS-1:0]   dct_buffer,
    output logic [3:0]           dct_count,
    output logic                 overflow
);
    localparam int BW = 2 * SLOTS;
    localparam logic [3:0] FULL = 4'(SLOTS);

    logic [BW-1:0]   buf_q, buf_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            ovf_q, ovf_d;
    logic            flush_pend_q, flush_pend_d;
    logic            frame_valid_q, frame_valid_d;
    logic [BW+3:0]   frame_data_q, frame_data_d;

    logic            ins;
    logic            drop;
    logic [BW+1:0]   shifted;
    logic [BW-1:0]   next_buf;
    logic [3:0]      next_cnt;
    logic            slot_free;
    logic            emit;

    always_comb begin
        ins       = dct_valid & trc_on & (cnt_q < FULL);
        drop      = dct_valid & trc_on & (cnt_q == FULL);
        // Newest code enters at [1:0]; the oldest drifts towards the MSBs.
        shifted   = {buf_q, dct_code};
        next_buf  = ins ? shifted[BW-1:0] : buf_q;
        next_cnt  = ins ? (cnt_q + 4'd1) : cnt_q;
        slot_free = ~frame_valid_q | frm.frame_ready;
        emit      = slot_free &
                    ((next_cnt == FULL) | ((flush | flush_pend_q) & (next_cnt != 4'd0)));
    end

    always_comb begin
        buf_d         = next_buf;
        cnt_d         = next_cnt;
        ovf_d         = ovf_q | drop;
        flush_pend_d  = flush_pend_q;
        frame_valid_d = frame_valid_q;
        frame_data_d  = frame_data_q;

        // A flush against an empty buffer has nothing to carry, so it is dropped.
        if (emit || (next_cnt == 4'd0)) begin
            flush_pend_d = 1'b0;
        end else if (flush) begin
            flush_pend_d = 1'b1;
        end

        if (emit) begin
            frame_data_d  = {next_cnt, next_buf};
            frame_valid_d = 1'b1;
            buf_d         = '0;
            cnt_d         = 4'd0;
        end else if (frame_valid_q && frm.frame_ready) begin
            frame_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            buf_q         <= '0;
            cnt_q         <= 4'd0;
            ovf_q         <= 1'b0;
            flush_pend_q  <= 1'b0;
            frame_valid_q <= 1'b0;
            frame_data_q  <= '0;
        end else begin
            buf_q         <= buf_d;
            cnt_q         <= cnt_d;
            ovf_q         <= ovf_d;
            flush_pend_q  <= flush_pend_d;
            frame_valid_q <= frame_valid_d;
            frame_data_q  <= frame_data_d;
        end
    end

    assign frm.frame_valid = frame_valid_q;
    assign frm.frame_data  = frame_data_q;
    assign dct_buffer      = buf_q;
    assign dct_count       = cnt_q;
    assign overflow        = ovf_q;
endmodule
